// File: rtl/grad_stream_if.sv
// Stream bundle for the gradient transmitter: gradient input side plus the
// downstream valid/ready output side.
interface grad_stream_if #(
  parameter int DATA_W = 17
);
  logic [DATA_W-1:0] grad_abs;
  logic              grad_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // Transmitter side: consumes gradients, drives the output stream.
  modport master (
    input  grad_abs, grad_valid, out_ready,
    output out_data, out_valid, out_last
  );

  // Producer/consumer side surrounding the transmitter.
  modport slave (
    output grad_abs, grad_valid, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/grad_stream_tx.sv
// Gradient stream transmitter: buffers one gradient magnitude per cycle in a
// show-ahead FIFO and emits it on a valid/ready stream with a per-line
// end marker. Inputs arriving while full (and not draining) are dropped and
// flagged by a sticky overflow bit.
module grad_stream_tx #(
  parameter int DATA_W   = 17,
  parameter int DEPTH    = 8,
  parameter int LINE_LEN = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  grad_stream_if.master         s_if,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                  overflow,
  input  logic                  clr_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ALMOST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] C_COL_ONE  = COL_W'(1);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [COL_W-1:0]  r_col;
  logic              r_ovf;
  logic              w_push, w_pop, w_drop;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_pop  = s_if.out_valid && s_if.out_ready;
  assign w_push = s_if.grad_valid && ((r_count < C_FULL) || w_pop);
  assign w_drop = s_if.grad_valid && !w_push;

  // Show-ahead output; data is forced to zero while empty so the stale
  // (unreset) storage never reaches the port.
  assign s_if.out_valid = (r_count != '0);
  assign s_if.out_data  = s_if.out_valid ? r_mem[r_rd_ptr] : '0;
  assign s_if.out_last  = s_if.out_valid && (r_col == C_LAST_COL);
  assign fifo_count     = r_count;
  assign overflow       = r_ovf;

  // Storage write; contents are data only and need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_if.grad_abs;
  end

  // Occupancy update and informational state tracking.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
    case (r_state)
      S_EMPTY:  if (w_push) w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_push && !w_pop && (r_count == C_ALMOST)) w_state_nxt = S_FULL;
        else if (w_pop && !w_push && (r_count == C_ONE)) w_state_nxt = S_EMPTY;
      end
      S_FULL:   if (w_pop && !w_push) w_state_nxt = S_ACTIVE;
      default:  w_state_nxt = S_EMPTY;
    endcase
  end

  // Control registers: pointers, occupancy, state, line column, overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_col    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_col    <= (r_col == C_LAST_COL) ? '0 : r_col + C_COL_ONE;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end
endmodule
